sensor_stream_gen: RTL and testbench



---
 rtl/sensor_gen_pkg.sv | 37 +++
 rtl/sensor_pattern_pix.sv | 36 +++
 rtl/sensor_stream_gen.sv | 180 ++++++++++++++++++
 tb/tb_sensor_stream_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sensor_gen_pkg.sv
// Shared types and constants for the synthetic sensor stream generator.
package sensor_gen_pkg;

    localparam int PIX_W       = 12;
    localparam int FRAME_CNT_W = 16;

    // Color bars step: eight bars spread evenly over the 12-bit range (7*585 = 4095).
    localparam logic [PIX_W-1:0] BAR_STEP = 12'd585;

    // Timing generator states; the fv/lv levels follow directly from the state.
    typedef enum logic [2:0] {
        IDLE,
        FV_LEAD,
        ACTIVE,
        HBLANK,
        FV_TRAIL,
        VBLANK
    } state_e;

    // Test pattern selector, encoded as on the pattern_sel port.
    typedef enum logic [1:0] {
        PAT_RAMP  = 2'd0,
        PAT_FLAT  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    // Counter width for a range of 'value' states, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sensor_pattern_pix.sv
// Combinational pixel value for the selected test pattern at coordinate (x, y).
module sensor_pattern_pix
    import sensor_gen_pkg::*;
#(
    parameter int               H_ACTIVE   = 1920,
    parameter int               X_W        = 11,
    parameter logic [PIX_W-1:0] FLAT_LEVEL = 12'h800
) (
    input  logic [X_W-1:0]   x_i,
    input  logic             y_lsb_i,
    input  logic [PIX_W-1:0] frame_cnt_i,
    input  pattern_e         pattern_i,
    output logic [PIX_W-1:0] pix_o
);

    // Pixels per color bar; H_ACTIVE is a multiple of 8, so this is exact.
    localparam int BAR_WIDTH = H_ACTIVE / 8;

    logic [X_W-1:0] bar_idx;

    assign bar_idx = x_i / X_W'(BAR_WIDTH);

    // Pattern mux: ramp scrolls by one code per frame, bars step by BAR_STEP.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        pix_o = '0;
        case (pattern_i)
            PAT_RAMP:  pix_o = PIX_W'(x_i) + frame_cnt_i;
            PAT_FLAT:  pix_o = FLAT_LEVEL;
            PAT_BARS:  pix_o = PIX_W'(bar_idx) * BAR_STEP;
            PAT_CHECK: pix_o = (x_i[0] ^ y_lsb_i) ? 12'hFFF : 12'h000;
            default:   pix_o = '0;
        endcase
    end

endmodule

// File: rtl/sensor_stream_gen.sv
// Synthetic raw-sensor source: fv/lv framing with programmable blanking and
// a 12-bit test pattern, standing in for the sensor receiver.
module sensor_stream_gen
    import sensor_gen_pkg::*;
#(
    parameter int               H_ACTIVE   = 1920,
    parameter int               V_ACTIVE   = 1080,
    parameter int               H_BLANK    = 280,
    parameter int               FV2LV      = 16,
    parameter int               LV2FV      = 16,
    parameter int               V_BLANK    = 1000,
    parameter logic [PIX_W-1:0] FLAT_LEVEL = 12'h800
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             pattern_sel,
    output logic                   fv_out,
    output logic                   lv_out,
    output logic [PIX_W-1:0]       data_out,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   frame_done
);

    localparam int X_W   = clog2_min1(H_ACTIVE);
    localparam int Y_W   = clog2_min1(V_ACTIVE);
    localparam int CNT_W = clog2_min1(max_int(max_int(FV2LV, LV2FV), max_int(H_BLANK, V_BLANK)));

    // Last value of each counter before the state is left.
    localparam logic [X_W-1:0]   X_LAST     = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(FV2LV - 1);
    localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(LV2FV - 1);
    localparam logic [CNT_W-1:0] VB_LAST    = CNT_W'(V_BLANK - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    pattern_e               pat_q, pat_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   fv_q, fv_d;
    logic                   lv_q, lv_d;
    logic [PIX_W-1:0]       data_q, data_d;
    logic                   done_q, done_d;
    logic [PIX_W-1:0]       pix;

    // Pixel for the coordinate that will be on the bus after the next edge.
    sensor_pattern_pix #(
        .H_ACTIVE   (H_ACTIVE),
        .X_W        (X_W),
        .FLAT_LEVEL (FLAT_LEVEL)
    ) u_pix (
        .x_i         (x_d),
        .y_lsb_i     (y_d[0]),
        .frame_cnt_i (frame_cnt_q[PIX_W-1:0]),
        .pattern_i   (pat_q),
        .pix_o       (pix)
    );

    // Next-state logic: framing FSM, beat coordinates, pattern latch and frame count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        x_d         = x_q;
        y_d         = y_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = FV_LEAD;
                    pat_d   = pattern_e'(pattern_sel);
                end
            end

            FV_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end

            ACTIVE: begin
                // The x coordinate times the line, so the blanking counter idles at 0.
                cnt_d = '0;
                if (x_q == X_LAST) begin
                    x_d     = '0;
                    state_d = (y_q == Y_LAST) ? FV_TRAIL : HBLANK;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end

            HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    y_d     = y_q + 1'b1;
                end
            end

            FV_TRAIL: begin
                if (cnt_q == TRAIL_LAST) begin
                    // frame_done and the count update land on the fv falling edge.
                    state_d     = VBLANK;
                    cnt_d       = '0;
                    y_d         = '0;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end

            VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = FV_LEAD;
                        pat_d   = pattern_e'(pattern_sel);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output levels are decoded from the next state so every output is a plain register.
    always_comb begin
        fv_d   = (state_d != IDLE) && (state_d != VBLANK);
        lv_d   = (state_d == ACTIVE);
        data_d = lv_d ? pix : '0;
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pat_q       <= PAT_RAMP;
            frame_cnt_q <= '0;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            fv_q        <= fv_d;
            lv_q        <= lv_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    assign fv_out     = fv_q;
    assign lv_out     = lv_q;
    assign data_out   = data_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_sensor_stream_gen.sv
// Directed bench for sensor_stream_gen with a pixel scoreboard.
module tb_sensor_stream_gen;

    localparam int H_ACTIVE = 16;
    localparam int V_ACTIVE = 4;
    localparam int H_BLANK  = 4;
    localparam int FV2LV    = 3;
    localparam int LV2FV    = 2;
    localparam int V_BLANK  = 5;

    localparam int LINE_PER = H_ACTIVE + H_BLANK;
    localparam int LV_SPAN  = V_ACTIVE * LINE_PER - H_BLANK;
    localparam int FV_HIGH  = FV2LV + V_ACTIVE * H_ACTIVE + (V_ACTIVE - 1) * H_BLANK + LV2FV;
    localparam int PERIOD   = FV_HIGH + V_BLANK;

    localparam logic [1:0] SEL_RAMP  = 2'd0;
    localparam logic [1:0] SEL_FLAT  = 2'd1;
    localparam logic [1:0] SEL_BARS  = 2'd2;
    localparam logic [1:0] SEL_CHECK = 2'd3;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        fv_out;
    logic        lv_out;
    logic [11:0] data_out;
    logic [15:0] frame_cnt;
    logic        frame_done;

    int          total = 0;
    int          bad   = 0;
    logic        mon_on = 1'b0;
    logic [11:0] pix_q[$];

    sensor_stream_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .H_BLANK    (H_BLANK),
        .FV2LV      (FV2LV),
        .LV2FV      (LV2FV),
        .V_BLANK    (V_BLANK),
        .FLAT_LEVEL (12'h800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .fv_out      (fv_out),
        .lv_out      (lv_out),
        .data_out    (data_out),
        .frame_cnt   (frame_cnt),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference pixel value straight from the pattern definitions.
    function automatic logic [11:0] exp_pix(input logic [1:0] pat, input int x, input int y, input int fc);
        case (pat)
            SEL_RAMP: return 12'((x + fc) % 4096);
            SEL_FLAT: return 12'h800;
            SEL_BARS: return 12'((x / (H_ACTIVE / 8)) * 585);
            default:  return (((x % 2) ^ (y % 2)) != 0) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    function automatic logic exp_fv(input int i);
        return i < FV_HIGH;
    endfunction

    function automatic logic exp_lv(input int i);
        int j;
        j = i - FV2LV;
        return (j >= 0) && (j < LV_SPAN) && ((j % LINE_PER) < H_ACTIVE);
    endfunction

    task automatic push_frame(input logic [1:0] pat, input int fc);
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++)
                pix_q.push_back(exp_pix(pat, x, y, fc));
    endtask

    // Pixel scoreboard: every lv beat pops one expected value; blanking must read 0.
    always @(negedge clk) begin
        if (mon_on) begin
            if (lv_out === 1'b1) begin
                check("pix_avail", 32'(pix_q.size() > 0), 32'd1);
                if (pix_q.size() > 0) check("pix", 32'(data_out), 32'(pix_q.pop_front()));
            end else begin
                check("data_blank", 32'(data_out), 32'd0);
            end
        end
    end

    // One frame from the first fv=1 sample; index 0 is the sample after the FV_LEAD entry edge.
    task automatic run_frame(input logic [1:0] pat, input int fc, input logic [1:0] next_sel,
                             input int drop_at, input int rst_at);
        push_frame(pat, fc);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk); #1;
            check("fv", 32'(fv_out), 32'(exp_fv(i)));
            check("lv", 32'(lv_out), 32'(exp_lv(i)));
            check("frame_done", 32'(frame_done), 32'(i == FV_HIGH));
            check("frame_cnt", 32'(frame_cnt), 32'(16'((i >= FV_HIGH) ? fc + 1 : fc)));
            if (i == 40) pattern_sel = next_sel;
            if (i == drop_at) enable = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                pix_q.delete();
                @(negedge clk); #1;
                check("rst_fv", 32'(fv_out), 32'd0);
                check("rst_lv", 32'(lv_out), 32'd0);
                check("rst_data", 32'(data_out), 32'd0);
                check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
                check("rst_frame_done", 32'(frame_done), 32'd0);
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        pattern_sel = SEL_RAMP;
        repeat (3) @(negedge clk);
        #1;
        check("reset_fv", 32'(fv_out), 32'd0);
        check("reset_lv", 32'(lv_out), 32'd0);
        check("reset_data", 32'(data_out), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        rst    = 1'b0;
        mon_on = 1'b1;

        // Idle with enable low: no frame may start.
        repeat (4) begin
            @(negedge clk); #1;
            check("idle_fv", 32'(fv_out), 32'd0);
        end

        // Three back-to-back frames; each mid-frame select change applies to the next frame only.
        pattern_sel = SEL_BARS;
        enable      = 1'b1;
        run_frame(SEL_BARS,  0, SEL_CHECK, -1, -1);
        run_frame(SEL_CHECK, 1, SEL_RAMP,  -1, -1);
        run_frame(SEL_RAMP,  2, SEL_FLAT,  -1, -1);

        // Enable dropped during line 1: frame and VBLANK complete, then the block parks.
        run_frame(SEL_FLAT, 3, SEL_BARS, 30, -1);
        repeat (8) begin
            @(negedge clk); #1;
            check("parked_fv", 32'(fv_out), 32'd0);
            check("parked_lv", 32'(lv_out), 32'd0);
            check("parked_frame_cnt", 32'(frame_cnt), 32'd4);
        end

        // Re-enable: fv rises on the sampling edge; reset lands in line 2 of this frame.
        enable = 1'b1;
        run_frame(SEL_BARS, 4, SEL_RAMP, -1, 50);

        // After reset the next frame restarts from FV_LEAD at x=y=0 with frame_cnt=0.
        run_frame(SEL_RAMP, 0, SEL_RAMP, -1, -1);

        check("pix_left", 32'(pix_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
